// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by ALU_Control and the EX-stage multiply sequencer.
// Contents:
//   alu_ctrl_e   - 3-bit ALU control codes produced by ALU_Control
//   mul_state_e  - multiply sequencer state encoding
//   is_mul_req() - decode of a live, unsquashed multiply in EX
package cpu_pkg;

    typedef enum logic [2:0] {
        ALUCTRL_AND = 3'b000,
        ALUCTRL_OR  = 3'b001,
        ALUCTRL_ADD = 3'b010,
        ALUCTRL_SUB = 3'b110,
        ALUCTRL_MUL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

    function automatic logic is_mul_req(input logic valid,
                                        input logic [2:0] alu_ctrl,
                                        input logic flush);
        return valid && (alu_ctrl == ALUCTRL_MUL) && !flush;
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: multiplicand, multiplier and accumulator registers.
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-low reset, clears all registers
//   load         in   capture operands, clear accumulator
//   step         in   perform one shift-add iteration
//   mcand_init   in   WIDTH  multiplicand to load
//   mplier_init  in   WIDTH  multiplier to load
//   acc          out  WIDTH  running product (mod 2^WIDTH)
//   mplier_zero  out  the iteration in progress consumes the last set multiplier
//                     bit, i.e. the multiplier will be zero after this step
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_init,
    input  logic [WIDTH-1:0] mplier_init,
    output logic [WIDTH-1:0] acc,
    output logic             mplier_zero
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= mcand_init;
            mplier <= mplier_init;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Looks at bits above bit 0 so the sequencer can exit on the same edge
    // that retires the last set bit, without waiting an extra cycle.
    assign mplier_zero = (mplier[WIDTH-1:1] == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// EX-stage iterative multiply sequencer beside the single-cycle ALU.
// A mul (ALUCtrl 3'b111) stalls the pipeline while the shift-add datapath
// iterates, then presents the low WIDTH product bits for one cycle.
// Every other ALU control code passes through untouched.
//
//   state  | meaning
//   S_IDLE | waiting for a mul; stall follows the request combinationally
//   S_RUN  | one shift-add iteration per cycle, pipeline held
//   S_DONE | product on data_o for one cycle, always returns to S_IDLE
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous active-low reset
//   valid_i    in   EX holds a live instruction
//   ALUCtrl_i  in   3      ALU control code
//   flush_i    in   EX instruction squashed
//   data1_i    in   WIDTH  multiplicand
//   data2_i    in   WIDTH  multiplier
//   stall_o    out  hold PC, IF/ID and ID/EX
//   done_o     out  data_o valid this cycle
//   data_o     out  WIDTH  product[WIDTH-1:0], zero outside S_DONE
module alu_mul_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             load;
    logic             step;
    logic             last_iter;
    logic [WIDTH-1:0] acc;
    logic             mplier_zero;

    // Gating with rst_i keeps stall low while reset is asserted, even though
    // the EX stage may still be presenting a mul.
    assign req  = rst_i && is_mul_req(valid_i, ALUCtrl_i, flush_i);
    assign load = (state == S_IDLE) && req;
    assign step = (state == S_RUN) && !flush_i;

    assign last_iter = (cnt == CNT_LAST) || (EARLY_OUT && mplier_zero);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (last_iter) begin
                        state <= S_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // The finished mul is still in EX here; ignoring it is what
                    // prevents a second acceptance of the same instruction.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        unique case (state)
            S_IDLE:  stall_o = req;
            S_RUN:   stall_o = !flush_i;
            S_DONE:  stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

    assign done_o = (state == S_DONE);
    assign data_o = done_o ? acc : '0;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load        (load),
        .step        (step),
        .mcand_init  (data1_i),
        .mplier_init (data2_i),
        .acc         (acc),
        .mplier_zero (mplier_zero)
    );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: one instance with EARLY_OUT=0
// and one with EARLY_OUT=1, sharing clock, reset and operand buses.
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid0, valid1;
    logic [2:0]   alu_ctrl;
    logic         flush;
    logic [W-1:0] d1, d2;
    logic         stall0, stall1, done0, done1;
    logic [W-1:0] data0, data1;

    logic         sel_r;
    logic         stall_sel, done_sel;
    logic [W-1:0] data_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.WIDTH(W), .EARLY_OUT(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid0), .ALUCtrl_i(alu_ctrl),
        .flush_i(flush), .data1_i(d1), .data2_i(d2),
        .stall_o(stall0), .done_o(done0), .data_o(data0)
    );

    alu_mul_sequencer #(.WIDTH(W), .EARLY_OUT(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid1), .ALUCtrl_i(alu_ctrl),
        .flush_i(flush), .data1_i(d1), .data2_i(d2),
        .stall_o(stall1), .done_o(done1), .data_o(data1)
    );

    assign stall_sel = sel_r ? stall1 : stall0;
    assign done_sel  = sel_r ? done1  : done0;
    assign data_sel  = sel_r ? data1  : data0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: product modulo 2^W from plain wide arithmetic.
    function automatic logic [W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[W-1:0];
    endfunction

    // Reference iteration count: all W bits normally; with early-out, the
    // multiplier's bit length (at least one iteration always runs).
    function automatic int ref_iters(input bit early, input logic [W-1:0] b);
        int n;
        if (!early) return W;
        n = 0;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return (n == 0) ? 1 : n;
    endfunction

    // Issue one mul from just after a rising edge; chain keeps valid high
    // after done so the caller can issue the next mul immediately.
    task automatic run_mul(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit chain, input string tag);
        int exp_iter, stall_cnt, done_at;
        logic [W-1:0] got;
        exp_iter  = ref_iters(sel, b);
        stall_cnt = 0;
        done_at   = -1;
        got       = '0;
        sel_r     = sel;
        d1 = a; d2 = b; alu_ctrl = 3'b111; flush = 1'b0;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        for (int k = 0; k < 80 && done_at < 0; k++) begin
            @(negedge clk);
            if (stall_sel) stall_cnt++;
            if (done_sel) begin
                done_at = k;
                got     = data_sel;
            end
            @(posedge clk); #1;
            // Operands are latched on acceptance; bus changes afterwards must not matter.
            if (k == 0) begin d1 = $urandom; d2 = $urandom; end
        end
        chk({tag, " stall_len"}, 64'(stall_cnt), 64'(exp_iter + 1));
        chk({tag, " done_cycle"}, 64'(done_at), 64'(exp_iter + 1));
        chk({tag, " product"}, 64'(got), 64'(ref_product(a, b)));
        if (!chain) begin
            valid0 = 1'b0; valid1 = 1'b0;
            @(negedge clk);
            chk({tag, " no_reaccept"}, {62'd0, stall_sel, done_sel}, 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int done_seen, stall_seen;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0; alu_ctrl = 3'b000;
        flush = 1'b0; d1 = '0; d2 = '0; sel_r = 1'b0;
        #12;
        chk("reset outputs dut0", {stall0, done0, data0}, '0);
        chk("reset outputs dut1", {stall1, done1, data1}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-mul codes pass through with no stall and no done.
        valid0 = 1'b1; alu_ctrl = 3'b010; d1 = 32'd7; d2 = 32'd6;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("add passthru", {stall0, done0, data0}, '0);
            @(posedge clk); #1;
        end
        foreach (ra[i]) if (i < 3) begin
            alu_ctrl = (i == 0) ? 3'b000 : (i == 1) ? 3'b001 : 3'b110;
            @(negedge clk);
            chk("other ctrl passthru", {stall0, done0}, 2'b00);
            @(posedge clk); #1;
        end
        // A flushed mul is not a request.
        alu_ctrl = 3'b111; flush = 1'b1;
        @(negedge clk);
        chk("flushed mul no req", {stall0, done0}, 2'b00);
        @(posedge clk); #1;
        flush = 1'b0; valid0 = 1'b0;

        run_mul(1'b0, 32'd7, 32'd6, 1'b0, "mul 7x6");
        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul ff x ff");
        run_mul(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mul -3x5");

        // Flush at T+10 of a running mul.
        sel_r = 1'b0;
        d1 = 32'd11; d2 = 32'd13; alu_ctrl = 3'b111; valid0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush stall drop", {62'd0, stall0, done0}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; valid0 = 1'b0;
        done_seen = 0; stall_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0) done_seen++;
            if (stall0) stall_seen++;
            @(posedge clk); #1;
        end
        chk("flush no done", 64'(done_seen), 64'd0);
        chk("flush idle", 64'(stall_seen), 64'd0);
        run_mul(1'b0, 32'd2, 32'd3, 1'b0, "mul 2x3 after flush");

        // Reset mid-RUN at T+5.
        d1 = 32'd100; d2 = 32'd200; alu_ctrl = 3'b111; valid0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("reset midrun outputs", {stall0, done0, data0}, '0);
        @(negedge clk);
        chk("reset held outputs", {stall0, done0, data0}, '0);
        valid0 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        done_seen = 0; stall_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0) done_seen++;
            if (stall0) stall_seen++;
            @(posedge clk); #1;
        end
        chk("post reset no done", 64'(done_seen), 64'd0);
        chk("post reset idle", 64'(stall_seen), 64'd0);
        run_mul(1'b0, 32'd9, 32'd9, 1'b0, "mul 9x9 after reset");

        // Early-out instance, back-to-back.
        run_mul(1'b1, 32'd5, 32'd3, 1'b1, "early 5x3");
        run_mul(1'b1, 32'd4, 32'd4, 1'b0, "early 4x4 b2b");
        run_mul(1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, "early x0");
        run_mul(1'b1, 32'd3, 32'h8000_0000, 1'b0, "early msb");

        // Randomized operands against the reference model.
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_mul(1'b0, ra, rb, (i % 3) == 0, "rand full");
        end
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_mul(1'b1, ra, rb, (i % 4) == 0, "rand early");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
